proj_nuc_streamer: RTL and testbench
====================================

Name: proj_nuc_streamer

Overview:
- Feeds the k-mer buffer path: unpacks packed nucleotide words from the sequence source and emits one DATA_BITS nucleotide per handshake.
- Issues a one-cycle start_over before each sequence so the downstream buffer is cleared.
- Flags the last nucleotide and reports completion to the sequence controller.
- Has a one-word prefetch register, so a continuous source sustains one nucleotide per cycle.

Parameters:
- DATA_BITS, 2: bits per nucleotide.
- WORD_NUCS, 16: nucleotides per input word.
- WORD_BITS, WORD_NUCS*DATA_BITS: input word width.
- LEN_W, 16: sequence-length counter width, in nucleotides.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- seq_start  in  1  start pulse; sampled only when seq_ready=1.
- seq_len  in  LEN_W  sequence length in nucleotides; sampled with seq_start.
- seq_abort  in  1  drop the current sequence.
- seq_ready  out  1  idle, accepts seq_start.
- seq_done  out  1  one-cycle completion pulse.
- in_word  in  WORD_BITS  packed nucleotides; nucleotide 0 in bits [DATA_BITS-1:0].
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- out_data  out  DATA_BITS  nucleotide.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  qualifies the final nucleotide of the sequence.
- out_start_over  out  1  downstream buffer clear.

Behaviour:
- Reset (async, active-high): state=IDLE; seq_ready=1; all other outputs 0; counters, word and prefetch registers cleared.
- FSM states: IDLE, CLEAR, EMIT, DONE.
- IDLE:
  - seq_ready=1.
  - seq_start with seq_len=0 -> DONE; no start_over, no output.
  - seq_start with seq_len>0 -> CLEAR. Latch nucs_left=seq_len and words_left=ceil(seq_len/WORD_NUCS).
- CLEAR:
  - Exactly one cycle, out_start_over=1, out_valid=0 -> EMIT.
  - in_ready may be high here (prefetch).
- Input side, in CLEAR and EMIT:
  - in_ready = words_left>0 && !pf_valid.
  - On accept: pf_word<=in_word, pf_valid<=1, words_left--.
  - in_ready=0 in IDLE and DONE; words beyond words_left are never requested.
- Word load: when cur_valid=0, or when the last nucleotide of cur is consumed, and pf_valid=1: cur<=pf_word, idx<=0, pf_valid clears. An accept in the same cycle refills pf.
- EMIT output:
  - out_valid = cur_valid.
  - out_data = cur[idx*DATA_BITS +: DATA_BITS], LSB nucleotide first.
  - out_last = out_valid && nucs_left==1.
- On out_valid&&out_ready:
  - nucs_left--, idx++.
  - idx==WORD_NUCS-1 -> cur_valid clears, unless reloaded from pf in the same cycle.
  - out_last -> DONE.
- Partial final word: unused upper nucleotides are discarded.
- out_data holds steady while out_valid&&!out_ready (AXI-style: no retraction, no change).
- DONE: seq_done=1 for one cycle -> IDLE. Registers are cleared, so a stale prefetch never leaks into the next sequence.
- seq_abort: in any non-IDLE state, next cycle -> IDLE with all valids cleared, no seq_done, and the remaining source words are not consumed. Abort beats any simultaneous handshake.
- seq_start while not IDLE: ignored.
- Latency and throughput:
  - seq_start to out_start_over: 1 cycle.
  - First out_valid: earliest 1 cycle after CLEAR when in_valid was high during CLEAR.
  - With in_valid and out_ready held high: one nucleotide per cycle, no bubbles at word boundaries.
- Integration: the k-mer buffer shifts every cycle. Its shift must be gated by out_valid&&out_ready (out_ready tied 1 at integration).
- Width rules:
  - idx is clog2(WORD_NUCS) bits and wraps naturally at WORD_NUCS=power of 2; WORD_NUCS must be a power of two.
  - words_left is LEN_W bits.
  - ceil = (seq_len + WORD_NUCS-1) >> log2(WORD_NUCS), computed in LEN_W+1 bits so seq_len near max does not overflow.

Decomposition:
- Package proj_pkg gains:
  - state enum nuc_stream_state_t {IDLE, CLEAR, EMIT, DONE};
  - constants NUC_BITS=2 and WORD_NUCS=16;
  - typedef nuc_t.
- One sub-module: proj_word_unpacker, which holds the cur/pf word registers and the idx mux. The FSM and counters stay at the top level.

Test Plan:
- seq_len=16, one word 0xE4E4E4E4, in_valid and out_ready always 1:
  - start_over 1 cycle after seq_start;
  - out_data sequence 0,1,2,3 repeated 4 times on 16 consecutive cycles;
  - out_last on the 16th;
  - seq_done the next cycle.
- seq_len=37, three words, continuous: exactly 3 in_ready accepts, 37 nucleotides, no bubble at nucleotides 16 and 32, last 11 nucleotides of word 3 dropped.
- seq_len=20, out_ready toggles 1-0-1-0: out_data/out_valid stable during stalls, 20 transfers, out_last only on the 20th.
- seq_len=0: seq_done pulse 1 cycle after start, no start_over, in_ready never high.
- Abort and reset:
  - seq_abort after 5 nucleotides of seq_len=32: IDLE next cycle, no seq_done, second word never accepted.
  - New seq_len=4 afterwards: start_over, then the correct 4 nucleotides from a fresh word.
  - rst asserted mid-EMIT: outputs 0 immediately (asynchronous), seq_ready=1 after release.
- seq_start pulsed during EMIT: ignored, current sequence completes unchanged.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types and defaults for the nucleotide streaming path.
package proj_pkg;

    localparam int NUC_BITS  = 2;
    localparam int WORD_NUCS = 16;

    typedef logic [NUC_BITS-1:0] nuc_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        EMIT,
        DONE
    } nuc_stream_state_t;

endpackage

// File: rtl/proj_nuc_streamer_if.sv
// Bundles the controller, word-source and nucleotide-sink handshakes of the streamer.
interface proj_nuc_streamer_if #(
    parameter int DATA_BITS = proj_pkg::NUC_BITS,
    parameter int WORD_NUCS = proj_pkg::WORD_NUCS,
    parameter int LEN_W     = 16
) ();
    localparam int WORD_BITS = WORD_NUCS * DATA_BITS;

    // sequence controller
    logic                 seq_start;
    logic [LEN_W-1:0]     seq_len;
    logic                 seq_abort;
    logic                 seq_ready;
    logic                 seq_done;
    // packed word source
    logic [WORD_BITS-1:0] in_word;
    logic                 in_valid;
    logic                 in_ready;
    // nucleotide sink (k-mer buffer)
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 out_start_over;

    modport master (
        output seq_start, seq_len, seq_abort, in_word, in_valid, out_ready,
        input  seq_ready, seq_done, in_ready, out_data, out_valid, out_last, out_start_over
    );

    modport slave (
        input  seq_start, seq_len, seq_abort, in_word, in_valid, out_ready,
        output seq_ready, seq_done, in_ready, out_data, out_valid, out_last, out_start_over
    );
endinterface

// File: rtl/proj_word_unpacker.sv
// Current/prefetch word pair plus the nucleotide select mux.
module proj_word_unpacker #(
    parameter int DATA_BITS = proj_pkg::NUC_BITS,
    parameter int WORD_NUCS = proj_pkg::WORD_NUCS,
    parameter int WORD_BITS = WORD_NUCS * DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [WORD_BITS-1:0] in_word,
    input  logic                 consume,
    output logic                 pf_valid,
    output logic                 cur_valid,
    output logic [DATA_BITS-1:0] nuc
);
    localparam int              IDX_W    = $clog2(WORD_NUCS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_NUCS - 1);

    logic [WORD_BITS-1:0] cur_word;
    logic [WORD_BITS-1:0] pf_word;
    logic [IDX_W-1:0]     idx;
    logic                 load;

    // Move the prefetch into cur when cur is empty or its final nucleotide leaves now,
    // which is what keeps word boundaries bubble-free.
    assign load = pf_valid && (!cur_valid || (consume && idx == IDX_LAST));
    assign nuc  = cur_word[idx*DATA_BITS +: DATA_BITS];

    // Current word: reload from prefetch, otherwise step through nucleotides LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_word  <= '0;
            idx       <= '0;
            cur_valid <= 1'b0;
        end else if (clear) begin
            cur_word  <= '0;
            idx       <= '0;
            cur_valid <= 1'b0;
        end else if (load) begin
            cur_word  <= pf_word;
            idx       <= '0;
            cur_valid <= 1'b1;
        end else if (consume) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_LAST) cur_valid <= 1'b0;
        end
    end

    // Prefetch word: filled on source accept, emptied when cur takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_word  <= '0;
            pf_valid <= 1'b0;
        end else if (clear) begin
            pf_word  <= '0;
            pf_valid <= 1'b0;
        end else if (accept) begin
            pf_word  <= in_word;
            pf_valid <= 1'b1;
        end else if (load) begin
            pf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/proj_nuc_streamer.sv
// Unpacks packed nucleotide words into a one-nucleotide-per-beat stream for the k-mer buffer.
// The buffer downstream shifts every cycle, so it must gate its shift with out_valid && out_ready.
module proj_nuc_streamer
    import proj_pkg::*;
#(
    parameter int DATA_BITS = proj_pkg::NUC_BITS,
    parameter int WORD_NUCS = proj_pkg::WORD_NUCS,
    parameter int WORD_BITS = WORD_NUCS * DATA_BITS,
    parameter int LEN_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    proj_nuc_streamer_if.slave  bus
);
    localparam int IDX_W = $clog2(WORD_NUCS);

    nuc_stream_state_t    state;
    logic [LEN_W-1:0]     nucs_left;
    logic [LEN_W-1:0]     words_left;
    logic                 seq_ready_r;
    logic                 seq_done_r;
    logic                 start_over_r;

    logic                 pf_valid;
    logic                 cur_valid;
    logic [DATA_BITS-1:0] nuc;
    logic                 in_phase;
    logic                 abort;
    logic                 accept;
    logic                 fire;
    logic                 unpack_clear;
    logic [LEN_W:0]       len_round;
    logic [LEN_W-1:0]     len_words;

    // Word count rounded up; one extra bit so lengths near the maximum do not wrap.
    assign len_round = {1'b0, bus.seq_len} + (LEN_W+1)'(WORD_NUCS - 1);
    assign len_words = LEN_W'(len_round >> IDX_W);

    assign in_phase = (state == CLEAR) || (state == EMIT);
    assign abort    = bus.seq_abort && (state != IDLE);

    // Abort wins over both handshakes so nothing moves in the cycle it is raised.
    assign bus.in_ready  = in_phase && (words_left != '0) && !pf_valid && !bus.seq_abort;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == EMIT) && cur_valid && !bus.seq_abort;
    assign bus.out_data  = nuc;
    assign bus.out_last  = bus.out_valid && (nucs_left == LEN_W'(1));
    assign fire          = bus.out_valid && bus.out_ready;

    assign bus.seq_ready      = seq_ready_r;
    assign bus.seq_done       = seq_done_r;
    assign bus.out_start_over = start_over_r;

    // Word registers are wiped outside CLEAR/EMIT so a leftover prefetch cannot leak forward.
    assign unpack_clear = !in_phase || abort;

    proj_word_unpacker #(
        .DATA_BITS (DATA_BITS),
        .WORD_NUCS (WORD_NUCS),
        .WORD_BITS (WORD_BITS)
    ) u_unpack (
        .clk       (clk),
        .rst       (rst),
        .clear     (unpack_clear),
        .accept    (accept),
        .in_word   (bus.in_word),
        .consume   (fire),
        .pf_valid  (pf_valid),
        .cur_valid (cur_valid),
        .nuc       (nuc)
    );

    // Sequence FSM with its counters and registered control pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            seq_ready_r  <= 1'b1;
            seq_done_r   <= 1'b0;
            start_over_r <= 1'b0;
            nucs_left    <= '0;
            words_left   <= '0;
        end else begin
            seq_done_r   <= 1'b0;
            start_over_r <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                seq_ready_r <= 1'b1;
                nucs_left   <= '0;
                words_left  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.seq_start) begin
                            seq_ready_r <= 1'b0;
                            if (bus.seq_len == '0) begin
                                state      <= DONE;
                                seq_done_r <= 1'b1;
                            end else begin
                                state        <= CLEAR;
                                start_over_r <= 1'b1;
                                nucs_left    <= bus.seq_len;
                                words_left   <= len_words;
                            end
                        end
                    end
                    CLEAR: begin
                        state <= EMIT;
                        if (accept) words_left <= words_left - LEN_W'(1);
                    end
                    EMIT: begin
                        if (accept) words_left <= words_left - LEN_W'(1);
                        if (fire) begin
                            nucs_left <= nucs_left - LEN_W'(1);
                            if (bus.out_last) begin
                                state      <= DONE;
                                seq_done_r <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state       <= IDLE;
                        seq_ready_r <= 1'b1;
                        nucs_left   <= '0;
                        words_left  <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proj_nuc_streamer.sv
// Bench for proj_nuc_streamer: table of sequences (directed + random) checked against a
// word/nucleotide-level reference, plus hand-written reset sequences.
module tb_proj_nuc_streamer;
    localparam int DB = 2;
    localparam int WN = 16;
    localparam int LW = 16;
    localparam int WB = WN * DB;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proj_nuc_streamer_if #(.DATA_BITS(DB), .WORD_NUCS(WN), .LEN_W(LW)) bus ();

    proj_nuc_streamer #(.DATA_BITS(DB), .WORD_NUCS(WN), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          len;
        int          p_in;      // percent chance in_valid offered
        int          p_out;     // percent chance out_ready; -1 = toggle 1,0,1,0
        int          abort_at;  // abort after this many transfers; 0 = never
        int          n_offer;   // number of distinct words the source will offer
        bit          mid_start; // pulse seq_start while emitting
        logic [WB-1:0] word;    // nonzero: every word uses this value
        int          exp_so;    // expected start_over pulses
        int          exp_done;  // expected seq_done pulses
        int          exp_acc;   // expected word accepts; -1 = not checked
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: nucleotide i of a sequence is field i%WN of word i/WN, LSB first.
    function automatic int ref_nuc(input logic [WB-1:0] w[$], input int i);
        logic [WB-1:0] t;
        t = w[i / WN] >> (DB * (i % WN));
        return int'(t[DB-1:0]);
    endfunction

    task automatic idle_inputs();
        bus.seq_start = 1'b0;
        bus.seq_len   = '0;
        bus.seq_abort = 1'b0;
        bus.in_word   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_seq(input int r, input vec_t v);
        logic [WB-1:0] words[$];
        int got[$];
        int nw, wi, acc, so_cnt, so_cyc, done_cnt, done_cyc;
        int first_fire, last_fire, last_cnt, last_pos, stall_err, irdy_seen;
        int cyc, abort_cyc, end_cyc, n_exp, mism, ready_after;
        bit stalled, mid_done, timed_out;
        logic [DB-1:0] stall_data;

        nw = (v.len + WN - 1) / WN;
        for (int i = 0; i < nw + 2; i++) words.push_back(v.word != '0 ? v.word : WB'($urandom));
        wi = 0; acc = 0; so_cnt = 0; so_cyc = -1; done_cnt = 0; done_cyc = -1;
        first_fire = -1; last_fire = -1; last_cnt = 0; last_pos = -1; stall_err = 0;
        irdy_seen = 0; abort_cyc = -1; end_cyc = -1; ready_after = 0;
        stalled = 1'b0; mid_done = 1'b0; stall_data = '0;

        @(posedge clk); #1;
        bus.seq_start = 1'b1;
        bus.seq_len   = LW'(v.len);
        bus.in_valid  = 1'b1;
        bus.in_word   = words[0];
        bus.out_ready = 1'b1;
        cyc = 0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            if (bus.out_start_over) begin so_cnt++; so_cyc = cyc; end
            if (bus.seq_done) begin done_cnt++; done_cyc = cyc; end
            if (bus.in_ready) irdy_seen++;
            if (stalled && !(bus.out_valid && bus.out_data == stall_data)) stall_err++;
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin acc++; wi++; end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(int'(bus.out_data));
                if (bus.out_last) begin last_cnt++; last_pos = got.size(); end
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            if ((abort_cyc >= 0 && cyc == abort_cyc + 1) || (done_cyc >= 0 && cyc == done_cyc + 1))
                ready_after = int'(bus.seq_ready);
            if (end_cyc < 0 && (done_cyc >= 0 || abort_cyc >= 0)) end_cyc = cyc + 3;
            if (cyc == end_cyc) break;
            @(posedge clk); #1;
            cyc++;
            bus.seq_start = 1'b0;
            if (v.mid_start && !mid_done && first_fire >= 0 && cyc == first_fire + 3) begin
                bus.seq_start = 1'b1;
                bus.seq_len   = LW'(5);
                mid_done      = 1'b1;
            end
            bus.seq_abort = 1'b0;
            if (v.abort_at > 0 && abort_cyc < 0 && got.size() == v.abort_at) begin
                bus.seq_abort = 1'b1;
                abort_cyc     = cyc;
            end
            if (abort_cyc >= 0) bus.in_valid = 1'b1;
            else bus.in_valid = (wi < v.n_offer) && ($urandom_range(1, 100) <= v.p_in);
            bus.in_word   = (wi < words.size()) ? words[wi] : '0;
            bus.out_ready = (v.p_out < 0) ? cyc[0] : ($urandom_range(1, 100) <= v.p_out);
        end
        timed_out = (cyc != end_cyc);
        idle_inputs();

        check($sformatf("r%0d_timeout", r), timed_out, 0);
        check($sformatf("r%0d_start_over_cnt", r), so_cnt, v.exp_so);
        if (v.exp_so > 0) check($sformatf("r%0d_start_over_cyc", r), so_cyc, 1);
        n_exp = (v.abort_at > 0) ? v.abort_at : v.len;
        check($sformatf("r%0d_xfer_cnt", r), got.size(), n_exp);
        mism = 0;
        for (int i = 0; i < got.size() && i < n_exp; i++)
            if (got[i] != ref_nuc(words, i)) mism++;
        check($sformatf("r%0d_data_mism", r), mism, 0);
        check($sformatf("r%0d_last_cnt", r), last_cnt, (v.abort_at == 0 && v.len > 0) ? 1 : 0);
        if (v.abort_at == 0 && v.len > 0) check($sformatf("r%0d_last_pos", r), last_pos, v.len);
        check($sformatf("r%0d_done_cnt", r), done_cnt, v.exp_done);
        if (v.exp_done > 0)
            check($sformatf("r%0d_done_cyc", r), done_cyc, (v.len == 0) ? 1 : last_fire + 1);
        check($sformatf("r%0d_ready_after", r), ready_after, 1);
        check($sformatf("r%0d_stall_hold", r), stall_err, 0);
        if (v.exp_acc >= 0) check($sformatf("r%0d_accepts", r), acc, v.exp_acc);
        if (v.len == 0) check($sformatf("r%0d_in_ready_seen", r), irdy_seen, 0);
        if (v.p_in == 100 && v.p_out == 100 && v.abort_at == 0 && v.len > 0)
            check($sformatf("r%0d_no_bubble", r), last_fire - first_fire, v.len - 1);
        @(posedge clk);
    endtask

    function automatic vec_t mk(input int len, input int p_in, input int p_out, input int abort_at,
                                input int n_offer, input bit mid, input logic [WB-1:0] word,
                                input int exp_so, input int exp_done, input int exp_acc);
        vec_t v;
        v.len = len; v.p_in = p_in; v.p_out = p_out; v.abort_at = abort_at; v.n_offer = n_offer;
        v.mid_start = mid; v.word = word; v.exp_so = exp_so; v.exp_done = exp_done; v.exp_acc = exp_acc;
        return v;
    endfunction

    initial begin
        vec_t v;
        bit seen;
        int len, ab;

        // len, p_in, p_out, abort_at, n_offer, mid, word, exp_so, exp_done, exp_acc
        tbl.push_back(mk(16, 100, 100, 0, 99, 1'b0, 32'hE4E4E4E4, 1, 1, 1));
        tbl.push_back(mk(37, 100, 100, 0, 99, 1'b0, '0, 1, 1, 3));
        tbl.push_back(mk(20, 100,  -1, 0, 99, 1'b0, '0, 1, 1, 2));
        tbl.push_back(mk( 0, 100, 100, 0, 99, 1'b0, '0, 0, 1, 0));
        tbl.push_back(mk(32, 100, 100, 5,  1, 1'b0, '0, 1, 0, 1));
        tbl.push_back(mk( 4, 100, 100, 0, 99, 1'b0, '0, 1, 1, 1));
        tbl.push_back(mk(40, 100, 100, 0, 99, 1'b1, '0, 1, 1, 3));
        tbl.push_back(mk(16,  30, 100, 0, 99, 1'b0, '0, 1, 1, 1));
        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(0, 70);
            ab  = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            tbl.push_back(mk(len, $urandom_range(20, 100), $urandom_range(20, 100), ab, 99, 1'b0, '0,
                             (len > 0) ? 1 : 0, (ab > 0) ? 0 : 1, (ab > 0) ? -1 : (len + WN - 1) / WN));
        end

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seq_ready", bus.seq_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_start_over", bus.out_start_over, 0);
        check("rst_seq_done", bus.seq_done, 0);
        check("rst_out_data", bus.out_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_seq_ready", bus.seq_ready, 1);

        foreach (tbl[r]) begin
            v = tbl[r];
            run_seq(r, v);
        end

        // Asynchronous reset in the middle of emission
        @(posedge clk); #1;
        bus.seq_start = 1'b1; bus.seq_len = LW'(32);
        bus.in_valid = 1'b1; bus.in_word = WB'($urandom); bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.seq_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rstmid_reached_emit", seen, 1);
        check("rstmid_busy", bus.seq_ready, 0);
        @(posedge clk); @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rstmid_out_valid", bus.out_valid, 0);
        check("rstmid_out_last", bus.out_last, 0);
        check("rstmid_in_ready", bus.in_ready, 0);
        check("rstmid_out_data", bus.out_data, 0);
        check("rstmid_seq_ready", bus.seq_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rstmid_ready_after", bus.seq_ready, 1);
        check("rstmid_valid_after", bus.out_valid, 0);

        // Fresh short sequence after the reset
        run_seq(100, mk(4, 100, 100, 0, 99, 1'b0, '0, 1, 1, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
